uart_rx: RTL and testbench

Serial receiver that sits directly downstream of the team's UART transmitter. It deserialises the transmitter's 11-bit frame: one start bit, 8 data bits LSB-first, and two stop bits. It oversamples the line on `clock_out` and stores completed bytes in a small show-ahead FIFO. Board logic reads the bytes through a valid/pop handshake and gets per-frame framing-error and overrun pulses.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 51 +++++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame-level constants
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Line levels of the framing bits; the idle line sits at the stop level.
    localparam logic START_LEVEL       = 1'b0;
    localparam logic STOP_LEVEL        = 1'b1;
    localparam int   DEFAULT_DATA_BITS = 8;

    // 2-of-3 vote used when several samples are taken per bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead FIFO for received bytes. The head entry is visible on `head`
// without a pop; `pop` advances to the next entry. A push is accepted while
// full only if a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock_out,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head reads as zero while empty so the output is defined right after reset.
    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Advance write and read pointers on accepted push and pop.
    always_ff @(posedge clock_out) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clock_out) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB-first, STOP_BITS stop bits.
// The line is oversampled OVERSAMPLE times per bit; finished bytes go into a
// small show-ahead FIFO read through rx_valid / rd_en.
// Build option: define UART_RX_MAJORITY_EN to decide every bit by a 2-of-3
// vote of the samples at mid-1, mid and mid+1 (decision one tick later).
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int STOP_BITS  = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock_out,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd_en,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int CNT_W  = $clog2((DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS) + 1;

`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC_I = OVERSAMPLE / 2;
`else
    localparam int START_DEC_I = OVERSAMPLE / 2 - 1;
`endif

    // The start decision is taken at mid-bit; the counter then restarts so
    // every later decision, one full bit period apart, lands on the same phase.
    localparam logic [TICK_W-1:0] START_DEC = TICK_W'(START_DEC_I);
    localparam logic [TICK_W-1:0] BIT_DEC   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0]  LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  LAST_STOP = CNT_W'(STOP_BITS - 1);

    rx_state_t            state;
    logic [TICK_W-1:0]    tick;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 sync_meta;
    logic                 rxs;
    logic                 bit_val;
    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;

    // NOTE: non-blocking assignments keep this a true two-stage chain; blocking ones would merge the flops.
    always_ff @(posedge clock_out) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rxs       <= 1'b1;
        end else begin
            sync_meta <= rx;
            rxs       <= sync_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    // Keep the two previous synchronised samples for the 2-of-3 vote.
    always_ff @(posedge clock_out) begin
        if (rst) hist <= 2'b11;
        else     hist <= {hist[0], rxs};
    end

    assign bit_val = maj3(hist[1], hist[0], rxs);
`else
    assign bit_val = rxs;
`endif

    // A byte is complete when the last stop bit is decided high.
    assign push = (state == STOP) && (tick == BIT_DEC) && (cnt == LAST_STOP) &&
                  (bit_val == STOP_LEVEL);
    assign busy = (state != IDLE);

    // Frame FSM: start qualification, data shifting, stop checking.
    always_ff @(posedge clock_out) begin
        if (rst) begin
            state     <= IDLE;
            tick      <= '0;
            cnt       <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    tick <= '0;
                    cnt  <= '0;
                    if (rxs == START_LEVEL) state <= START;
                end
                START: begin
                    if (tick == START_DEC) begin
                        tick  <= '0;
                        state <= (bit_val == START_LEVEL) ? DATA : IDLE;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == BIT_DEC) begin
                        tick  <= '0;
                        shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                        if (cnt == LAST_DATA) begin
                            cnt   <= '0;
                            state <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    if (tick == BIT_DEC) begin
                        tick <= '0;
                        if (bit_val != STOP_LEVEL) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (cnt == LAST_STOP) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flag a good byte that the full FIFO cannot take this cycle.
    always_ff @(posedge clock_out) begin
        if (rst) overrun <= 1'b0;
        else     overrun <= push && fifo_full && !(rd_en && rx_valid);
    end

    assign rx_valid = !fifo_empty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_out (clock_out),
        .rst       (rst),
        .push      (push),
        .push_data (shreg),
        .pop       (rd_en),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames, a vector table and randomized
// frames checked against a queue-based model of the receiver.
module tb_uart_rx;

    localparam int OS    = 16;
    localparam int DB    = 8;
    localparam int SB    = 2;
    localparam int DEPTH = 4;
    localparam int FRAME = (1 + DB + SB) * OS;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic          clock_out;
    logic          rst;
    logic          rx;
    logic          rd_en;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    uart_rx #(
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB),
        .STOP_BITS  (SB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock_out (clock_out),
        .rst       (rst),
        .rx        (rx),
        .rd_en     (rd_en),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial begin
        clock_out = 1'b0;
        forever #5 clock_out = ~clock_out;
    end

    // Edge index after which the decision on frame bit b (0 = start) becomes
    // visible, counted from the edge that first sees the falling edge:
    // 3 edges to enter START, bit b decided at tick b*OS + OS/2 - 1 (+1 with
    // majority voting), result registered on the following edge.
    function automatic int effect_edge(input int b);
        return 3 + b * OS + OS / 2 - 1 + MAJ + 1;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Cycle counter and output monitor.
    int cyc            = 0;
    int fe_pulses      = 0;
    int ov_pulses      = 0;
    int long_pulses    = 0;
    int fe_rise_cyc    = -1;
    int ov_rise_cyc    = -1;
    int valid_rise_cyc = -1;
    logic fe_prev = 1'b0, ov_prev = 1'b0, valid_prev = 1'b0;

    always @(posedge clock_out) cyc <= cyc + 1;

    always @(negedge clock_out) begin
        if (frame_err === 1'b1) begin
            if (fe_prev) long_pulses++;
            else begin
                fe_pulses++;
                fe_rise_cyc = cyc;
            end
        end
        if (overrun === 1'b1) begin
            if (ov_prev) long_pulses++;
            else begin
                ov_pulses++;
                ov_rise_cyc = cyc;
            end
        end
        if (rx_valid === 1'b1 && !valid_prev) valid_rise_cyc = cyc;
        fe_prev    = (frame_err === 1'b1);
        ov_prev    = (overrun === 1'b1);
        valid_prev = (rx_valid === 1'b1);
    end

    int frame_c0 = 0;

    // Drive one frame; stops[0] is the first stop bit. pop_at >= 0 raises
    // rd_en at that offset; glitch inverts the line for one tick at mid-bit.
    task automatic send_frame(input logic [7:0] d, input logic [1:0] stops,
                              input int pop_at, input bit glitch);
        logic [1+DB+SB-1:0] bits;
        bits = {stops, d, 1'b0};
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clock_out);
            if (i == 0) frame_c0 = cyc;
            rx    = bits[i / OS] ^ (glitch && ((i % OS) == OS / 2));
            rd_en = (i == pop_at);
        end
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock_out);
            rx    = 1'b1;
            rd_en = 1'b0;
        end
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        @(negedge clock_out);
        check({name, " valid"}, 32'(rx_valid), 32'd1);
        check({name, " data"}, 32'(rx_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clock_out);
        rd_en = 1'b0;
    endtask

    task automatic expect_empty(input string name);
        @(negedge clock_out);
        check(name, 32'(rx_valid), 32'd0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic [1:0] stops;
        logic       exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] mq[$];
    int         fe0, ov0, exp_fe, exp_ov;

    initial begin
        logic [1+DB+SB-1:0] pbits;
        rst   = 1'b1;
        rx    = 1'b1;
        rd_en = 1'b0;

        vecs[0] = '{8'h00, 2'b11, 1'b1, 0};
        vecs[1] = '{8'hFF, 2'b11, 1'b1, 0};
        vecs[2] = '{8'h55, 2'b11, 1'b1, 0};
        vecs[3] = '{8'h80, 2'b01, 1'b0, 1};
        vecs[4] = '{8'h6D, 2'b10, 1'b0, 1};

        // Reset: two cycles with the line idle.
        @(negedge clock_out);
        @(negedge clock_out);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset overrun", 32'(overrun), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        idle(5);

        // Good frame 0xA5 and its exact arrival cycle.
        fe0 = fe_pulses;
        ov0 = ov_pulses;
        send_frame(8'hA5, 2'b11, -1, 1'b0);
        check("good latency", 32'(valid_rise_cyc - frame_c0), 32'(effect_edge(1 + DB + SB - 1)));
        pop_expect("good", 8'hA5);
        expect_empty("good popped");
        idle(5);
        check("good no frame_err", 32'(fe_pulses - fe0), 32'd0);
        check("good no overrun", 32'(ov_pulses - ov0), 32'd0);

        // False start: 4-tick low glitch.
        fe0 = fe_pulses;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock_out);
            rx = 1'b0;
        end
        @(negedge clock_out);
        rx = 1'b1;
        check("glitch busy", 32'(busy), 32'd1);
        idle(30);
        check("glitch back idle", 32'(busy), 32'd0);
        check("glitch no byte", 32'(rx_valid), 32'd0);
        check("glitch no frame_err", 32'(fe_pulses - fe0), 32'd0);

        // Framing error: first stop bit low.
        fe0 = fe_pulses;
        send_frame(8'h3C, 2'b10, -1, 1'b0);
        check("frame_err timing", 32'(fe_rise_cyc - frame_c0), 32'(effect_edge(1 + DB)));
        idle(40);
        check("frame_err count", 32'(fe_pulses - fe0), 32'd1);
        check("frame_err no byte", 32'(rx_valid), 32'd0);
        check("frame_err idle", 32'(busy), 32'd0);

        // Vector table.
        for (int v = 0; v < 5; v++) begin
            fe0 = fe_pulses;
            send_frame(vecs[v].data, vecs[v].stops, -1, 1'b0);
            idle(30);
            check($sformatf("vec%0d valid", v), 32'(rx_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) pop_expect($sformatf("vec%0d", v), vecs[v].data);
            check($sformatf("vec%0d frame_err", v), 32'(fe_pulses - fe0), 32'(vecs[v].exp_fe));
        end
        expect_empty("vec drained");

        // Overrun: five back-to-back frames, no reads.
        ov0 = ov_pulses;
        for (int k = 1; k <= 5; k++) send_frame(8'(k), 2'b11, -1, 1'b0);
        check("overrun timing", 32'(ov_rise_cyc - frame_c0), 32'(effect_edge(1 + DB + SB - 1)));
        idle(10);
        check("overrun count", 32'(ov_pulses - ov0), 32'd1);
        for (int k = 1; k <= 4; k++) pop_expect("overrun pop", 8'(k));
        expect_empty("overrun drained");

        // Full FIFO with a pop in the push cycle: both happen, no overrun.
        ov0 = ov_pulses;
        for (int k = 0; k < 4; k++) send_frame(8'(8'h11 + k), 2'b11, -1, 1'b0);
        send_frame(8'h15, 2'b11, effect_edge(1 + DB + SB - 1) - 1, 1'b0);
        idle(10);
        check("push+pop no overrun", 32'(ov_pulses - ov0), 32'd0);
        for (int k = 0; k < 4; k++) pop_expect("push+pop", 8'(8'h12 + k));
        expect_empty("push+pop drained");

        // Reset mid-DATA with a byte already buffered, then a clean frame.
        send_frame(8'h42, 2'b11, -1, 1'b0);
        idle(5);
        pbits = {2'b11, 8'h99, 1'b0};
        for (int i = 0; i < 60; i++) begin
            @(negedge clock_out);
            rx = pbits[i / OS];
        end
        @(negedge clock_out);
        check("mid-frame busy", 32'(busy), 32'd1);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clock_out);
        @(negedge clock_out);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset fifo", 32'(rx_valid), 32'd0);
        rst = 1'b0;
        idle(10);
        send_frame(8'h7E, 2'b11, -1, 1'b0);
        idle(10);
        pop_expect("after reset", 8'h7E);
        expect_empty("after reset only one");

`ifdef UART_RX_MAJORITY_EN
        // One-tick inverted glitch at every mid-bit is voted out.
        send_frame(8'hC3, 2'b11, -1, 1'b1);
        idle(10);
        pop_expect("majority glitch", 8'hC3);
        expect_empty("majority glitch single");
`endif

        // Randomized frames against a queue model of the receive buffer.
        fe0    = fe_pulses;
        ov0    = ov_pulses;
        exp_fe = 0;
        exp_ov = 0;
        for (int n = 0; n < 12; n++) begin
            logic [7:0] d;
            logic [1:0] stops;
            int         r;
            int         npop;
            d     = 8'($urandom_range(0, 255));
            r     = int'($urandom_range(0, 5));
            stops = (r == 4) ? 2'b10 : (r == 5) ? 2'b01 : 2'b11;
            send_frame(d, stops, -1, 1'b0);
            idle(20);
            if (stops == 2'b11) begin
                if (mq.size() < DEPTH) mq.push_back(d);
                else exp_ov++;
            end else begin
                exp_fe++;
            end
            npop = int'($urandom_range(0, 2));
            for (int p = 0; p < npop; p++) begin
                if (mq.size() > 0) pop_expect("rand pop", mq.pop_front());
                else expect_empty("rand empty");
            end
        end
        check("rand frame_err count", 32'(fe_pulses - fe0), 32'(exp_fe));
        check("rand overrun count", 32'(ov_pulses - ov0), 32'(exp_ov));
        while (mq.size() > 0) pop_expect("rand drain", mq.pop_front());
        expect_empty("rand drained");

        idle(5);
        check("pulse width", 32'(long_pulses), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
